// File: rtl/led_stripe_pkg.sv
// led_stripe_pkg
//   Shared definitions for the one-wire LED-stripe encoder:
//   - state_t : encoder FSM states (IDLE, FETCH, HIGH, LOW, LATCH)
//   - default symbol / latch timings for WS2812B and SK6812 at 50 MHz
//   - max_cyc : helper used to size the symbol timer
package led_stripe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  // WS2812B at 50 MHz (20 ns per cycle)
  localparam int WS2812B_T0H_CYC = 20;    // 0.40 us
  localparam int WS2812B_T0L_CYC = 42;    // 0.85 us
  localparam int WS2812B_T1H_CYC = 40;    // 0.80 us
  localparam int WS2812B_T1L_CYC = 22;    // 0.45 us
  localparam int WS2812B_RST_CYC = 2600;  // 52 us latch

  // SK6812 at 50 MHz (20 ns per cycle)
  localparam int SK6812_T0H_CYC = 15;     // 0.30 us
  localparam int SK6812_T0L_CYC = 45;     // 0.90 us
  localparam int SK6812_T1H_CYC = 30;     // 0.60 us
  localparam int SK6812_T1L_CYC = 30;     // 0.60 us
  localparam int SK6812_RST_CYC = 4000;   // 80 us latch

  // Largest of the five period lengths; the shared timer must hold any of them.
  function automatic int max_cyc(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/led_symbol_timer.sv
// led_symbol_timer
//   Loadable down-counter used for the HIGH, LOW and LATCH periods.
//   Loading value N-1 makes 'expired' assert in the Nth cycle after the load,
//   so a state that loads on entry and leaves on 'expired' lasts exactly N cycles.
// Ports
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   load       : load load_value and start counting (wins over expiry)
//   load_value : period length minus one
//   expired    : high in the cycle the running count reaches zero
module led_symbol_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;
  logic             running;

  // 'running' stops the counter from reporting expiry again while it sits
  // at zero between periods (e.g. while the encoder waits in FETCH).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= load_value;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - WIDTH'(1);
      end
    end
  end

  assign expired = running && (count == '0);

endmodule

// File: rtl/led_stripe_encoder.sv
// led_stripe_encoder
//   One-wire LED-stripe frame encoder (WS2812/SK6812 class). Pixels arrive on a
//   valid/ready stream and are sent MSB first as high/low symbols, followed by a
//   low latch period that ends the frame.
// Ports
//   clk            : system clock
//   rstn           : asynchronous active-low reset
//   frame_start    : one-cycle pulse to begin a frame (ignored while busy)
//   pix_data       : pixel word, MSB transmitted first
//   pix_valid      : pix_data valid
//   pix_ready      : pixel accepted this cycle when pix_valid is high (FETCH only)
//   busy           : frame in progress
//   frame_done     : one-cycle pulse after the latch period
//   underrun       : sticky, pixel missing when needed; cleared by frame_start
//   led_stripe_pin : registered serial output
// PIX_BITS must be at least 2.
module led_stripe_encoder
  import led_stripe_pkg::*;
#(
  parameter int LED_COUNT = 60,
  parameter int PIX_BITS  = 24,
  parameter int T0H_CYC   = WS2812B_T0H_CYC,
  parameter int T0L_CYC   = WS2812B_T0L_CYC,
  parameter int T1H_CYC   = WS2812B_T1H_CYC,
  parameter int T1L_CYC   = WS2812B_T1L_CYC,
  parameter int RST_CYC   = WS2812B_RST_CYC
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                frame_start,
  input  logic [PIX_BITS-1:0] pix_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun,
  output logic                led_stripe_pin
);

  localparam int TIMER_W   = $clog2(max_cyc(T0H_CYC, T0L_CYC, T1H_CYC, T1L_CYC, RST_CYC)) + 1;
  localparam int PIX_CNT_W = $clog2(LED_COUNT) + 1;
  localparam int BIT_CNT_W = $clog2(PIX_BITS) + 1;

  localparam logic [TIMER_W-1:0]   T0H_LOAD = TIMER_W'(T0H_CYC - 1);
  localparam logic [TIMER_W-1:0]   T0L_LOAD = TIMER_W'(T0L_CYC - 1);
  localparam logic [TIMER_W-1:0]   T1H_LOAD = TIMER_W'(T1H_CYC - 1);
  localparam logic [TIMER_W-1:0]   T1L_LOAD = TIMER_W'(T1L_CYC - 1);
  localparam logic [TIMER_W-1:0]   RST_LOAD = TIMER_W'(RST_CYC - 1);
  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(LED_COUNT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PIX_BITS - 1);

  state_t state, state_next;

  logic [PIX_BITS-1:0]  shift_q;
  logic [PIX_BITS-1:0]  shift_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic                 pin_q, pin_next;
  logic                 underrun_q;
  logic                 frame_done_q;

  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 expired;

  logic                 start_frame, load_pixel, shift_bit, pix_inc;
  logic                 set_underrun, done_next;

  led_symbol_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (expired)
  );

  // Next bit is looked ahead from the shifted word so the following HIGH
  // starts on the very edge that ends the current LOW.
  assign shift_next = {shift_q[PIX_BITS-2:0], 1'b0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. The pin value is decided here and
  // registered below, so every transition that enters HIGH also raises the
  // pin on the same edge. frame_start is masked in the frame_done cycle so a
  // start that coincides with the end of the latch has to be re-issued.
  always_comb begin
    state_next   = state;
    timer_load   = 1'b0;
    timer_value  = '0;
    pin_next     = 1'b0;
    pix_ready    = 1'b0;
    start_frame  = 1'b0;
    load_pixel   = 1'b0;
    shift_bit    = 1'b0;
    pix_inc      = 1'b0;
    set_underrun = 1'b0;
    done_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start && !frame_done_q) begin
          start_frame = 1'b1;
          state_next  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          load_pixel  = 1'b1;
          pin_next    = 1'b1;
          timer_load  = 1'b1;
          timer_value = pix_data[PIX_BITS-1] ? T1H_LOAD : T0H_LOAD;
          state_next  = ST_HIGH;
        end else begin
          set_underrun = 1'b1;
        end
      end
      ST_HIGH: begin
        pin_next = 1'b1;
        if (expired) begin
          pin_next    = 1'b0;
          timer_load  = 1'b1;
          timer_value = shift_q[PIX_BITS-1] ? T1L_LOAD : T0L_LOAD;
          state_next  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (expired) begin
          if (bit_cnt != '0) begin
            shift_bit   = 1'b1;
            pin_next    = 1'b1;
            timer_load  = 1'b1;
            timer_value = shift_next[PIX_BITS-1] ? T1H_LOAD : T0H_LOAD;
            state_next  = ST_HIGH;
          end else if (pix_cnt < LAST_PIX) begin
            pix_inc    = 1'b1;
            state_next = ST_FETCH;
          end else begin
            timer_load  = 1'b1;
            timer_value = RST_LOAD;
            state_next  = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (expired) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: shift register, bit/pixel counters, registered pin and flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      pin_q        <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pin_q        <= pin_next;
      frame_done_q <= done_next;
      if (start_frame) begin
        pix_cnt    <= '0;
        underrun_q <= 1'b0;
      end else if (pix_inc) begin
        pix_cnt <= pix_cnt + PIX_CNT_W'(1);
      end
      if (set_underrun) begin
        underrun_q <= 1'b1;
      end
      if (load_pixel) begin
        shift_q <= pix_data;
        bit_cnt <= LAST_BIT;
      end else if (shift_bit) begin
        shift_q <= shift_next;
        bit_cnt <= bit_cnt - BIT_CNT_W'(1);
      end
    end
  end

  assign busy           = (state != ST_IDLE);
  assign frame_done     = frame_done_q;
  assign underrun       = underrun_q;
  assign led_stripe_pin = pin_q;

endmodule

// File: tb/tb_led_stripe_encoder.sv
// tb_led_stripe_encoder
//   Scoreboard bench for led_stripe_encoder. Frame stimulus pushes the expected
//   (high, low) width of every symbol; a monitor measures pin pulses and pops
//   the queue as each symbol completes. A second instance (32-bit pixels, one
//   LED) is driven with pix_valid held high for the whole frame.
module tb_led_stripe_encoder;

  localparam int T0H = 2;
  localparam int T0L = 4;
  localparam int T1H = 4;
  localparam int T1L = 2;
  localparam int RST = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  logic       a_frame_start = 1'b0;
  logic [7:0] a_pix_data    = '0;
  logic       a_pix_valid   = 1'b0;
  logic       a_pix_ready, a_busy, a_frame_done, a_underrun, a_pin;

  logic        b_frame_start = 1'b0;
  logic [31:0] b_pix_data    = '0;
  logic        b_pix_valid   = 1'b0;
  logic        b_pix_ready, b_busy, b_frame_done, b_underrun, b_pin;

  led_stripe_encoder #(
    .LED_COUNT (2), .PIX_BITS (8),
    .T0H_CYC (T0H), .T0L_CYC (T0L), .T1H_CYC (T1H), .T1L_CYC (T1L), .RST_CYC (RST)
  ) dut_a (
    .clk            (clk),
    .rstn           (rstn),
    .frame_start    (a_frame_start),
    .pix_data       (a_pix_data),
    .pix_valid      (a_pix_valid),
    .pix_ready      (a_pix_ready),
    .busy           (a_busy),
    .frame_done     (a_frame_done),
    .underrun       (a_underrun),
    .led_stripe_pin (a_pin)
  );

  led_stripe_encoder #(
    .LED_COUNT (1), .PIX_BITS (32),
    .T0H_CYC (T0H), .T0L_CYC (T0L), .T1H_CYC (T1H), .T1L_CYC (T1L), .RST_CYC (RST)
  ) dut_b (
    .clk            (clk),
    .rstn           (rstn),
    .frame_start    (b_frame_start),
    .pix_data       (b_pix_data),
    .pix_valid      (b_pix_valid),
    .pix_ready      (b_pix_ready),
    .busy           (b_busy),
    .frame_done     (b_frame_done),
    .underrun       (b_underrun),
    .led_stripe_pin (b_pin)
  );

  typedef struct {
    int hi;
    int lo;
  } sym_t;

  sym_t expect_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   done_count = 0;
  int   busy_drops = 0;
  bit   in_frame   = 1'b0;
  int   mon_hi     = 0;
  int   mon_lo     = 0;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic score_symbol(input int hi, input int lo);
    sym_t e;
    if (expect_q.size() == 0) begin
      check_output("unexpected_symbol_high", hi, 0);
    end else begin
      e = expect_q.pop_front();
      check_output("symbol_high", hi, e.hi);
      check_output("symbol_low", lo, e.lo);
    end
  endtask

  // Expected symbols of one 8-bit pixel; tail_low is added to the last low.
  task automatic push_pixel(input logic [7:0] p, input int tail_low);
    for (int i = 7; i >= 0; i--) begin
      sym_t s;
      s.hi = p[i] ? T1H : T0H;
      s.lo = p[i] ? T1L : T0L;
      if (i == 0) s.lo += tail_low;
      expect_q.push_back(s);
    end
  endtask

  // Monitor: high width counted while pin is high, low width until the next
  // rising edge or until frame_done closes the last symbol of the frame.
  always @(negedge clk) begin
    if (!rstn) begin
      mon_hi = 0;
      mon_lo = 0;
    end else begin
      if (a_frame_done) done_count++;
      if (in_frame && !a_busy && !a_frame_done) busy_drops++;
      if (a_pin) begin
        if (mon_lo != 0) begin
          score_symbol(mon_hi, mon_lo);
          mon_hi = 0;
          mon_lo = 0;
        end
        mon_hi++;
      end else if (mon_hi != 0) begin
        if (a_frame_done) begin
          score_symbol(mon_hi, mon_lo);
          mon_hi = 0;
          mon_lo = 0;
        end else begin
          mon_lo++;
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!a_pix_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!a_pix_ready) check_output(name, 0, 1);
  endtask

  // One two-pixel frame on dut_a. delay = FETCH cycles with pix_valid low
  // before the second pixel; poke_mid / poke_done pulse frame_start during
  // HIGH and in the frame_done cycle.
  task automatic apply_stimulus(input logic [7:0] p0, input logic [7:0] p1,
                                input int delay, input bit poke_mid, input bit poke_done);
    int n;
    push_pixel(p0, 1 + delay);
    push_pixel(p1, RST);
    @(negedge clk);
    a_frame_start = 1'b1;
    @(negedge clk);
    a_frame_start = 1'b0;
    in_frame = 1'b1;
    check_output("underrun_cleared_at_start", a_underrun, 0);
    wait_ready("ready_timeout_p0");
    a_pix_data  = p0;
    a_pix_valid = 1'b1;
    @(negedge clk);
    a_pix_valid = 1'b0;
    if (poke_mid) begin
      a_frame_start = 1'b1;
      @(negedge clk);
      a_frame_start = 1'b0;
    end
    wait_ready("ready_timeout_p1");
    repeat (delay) @(negedge clk);
    a_pix_data  = p1;
    a_pix_valid = 1'b1;
    @(negedge clk);
    a_pix_valid = 1'b0;
    n = 0;
    while (!a_frame_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    in_frame = 1'b0;
    if (!a_frame_done) begin
      check_output("frame_done_timeout", 0, 1);
    end else begin
      check_output("busy_in_done_cycle", a_busy, 0);
      if (poke_done) begin
        a_frame_start = 1'b1;
        @(negedge clk);
        a_frame_start = 1'b0;
      end
    end
  endtask

  task automatic after_frame(input int exp_done);
    repeat (3) @(negedge clk);
    check_output("frame_done_count", done_count, exp_done);
    check_output("busy_drops", busy_drops, 0);
    check_output("busy_after_frame", a_busy, 0);
    check_output("pin_after_frame", a_pin, 0);
  endtask

  initial begin
    int n, highs, ready_cycles, rises, ones, zeros, hi;
    logic prev;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_pin", a_pin, 0);
    check_output("reset_ready", a_pix_ready, 0);
    check_output("reset_busy", a_busy, 0);
    check_output("reset_frame_done", a_frame_done, 0);
    check_output("reset_underrun", a_underrun, 0);
    check_output("reset_b_busy", b_busy, 0);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] frame A5,01");
    apply_stimulus(8'hA5, 8'h01, 0, 1'b0, 1'b0);
    after_frame(1);
    check_output("underrun_frame1", a_underrun, 0);

    $display("[TB] frame FF,00 with ignored starts");
    apply_stimulus(8'hFF, 8'h00, 0, 1'b1, 1'b1);
    after_frame(2);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_pin || a_busy) highs++;
    end
    check_output("idle_after_ignored_start", highs, 0);
    check_output("frame_done_count_idle", done_count, 2);

    $display("[TB] frame 3C,C3 with 20-cycle underrun");
    apply_stimulus(8'h3C, 8'hC3, 20, 1'b0, 1'b0);
    after_frame(3);
    check_output("underrun_set", a_underrun, 1);
    repeat (10) @(negedge clk);
    check_output("underrun_sticky", a_underrun, 1);

    $display("[TB] frame 5A,80 clears underrun");
    apply_stimulus(8'h5A, 8'h80, 0, 1'b0, 1'b0);
    after_frame(4);
    check_output("underrun_clean_frame", a_underrun, 0);

    $display("[TB] reset mid-HIGH");
    a_pix_data  = 8'hFF;
    a_pix_valid = 1'b1;
    @(negedge clk);
    a_frame_start = 1'b1;
    @(negedge clk);
    a_frame_start = 1'b0;
    check_output("pin_low_in_fetch", a_pin, 0);
    @(negedge clk);
    check_output("pin_rise_two_cycles", a_pin, 1);
    a_pix_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_output("async_reset_pin", a_pin, 0);
    check_output("async_reset_busy", a_busy, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_output("post_reset_busy", a_busy, 0);
    check_output("post_reset_pin", a_pin, 0);

    $display("[TB] clean frame 96,69 after reset");
    apply_stimulus(8'h96, 8'h69, 0, 1'b0, 1'b0);
    after_frame(5);

    $display("[TB] 32-bit single-LED frame");
    b_pix_data  = 32'hF0F0_0001;
    b_pix_valid = 1'b1;
    @(negedge clk);
    b_frame_start = 1'b1;
    @(negedge clk);
    b_frame_start = 1'b0;
    check_output("b_pin_low_in_fetch", b_pin, 0);
    ready_cycles = 0;
    rises = 0;
    ones  = 0;
    zeros = 0;
    hi    = 0;
    prev  = 1'b0;
    n     = 0;
    while (!b_frame_done && n < 2000) begin
      if (b_pix_ready) ready_cycles++;
      if (b_pin && !prev) rises++;
      if (b_pin) begin
        hi++;
      end else if (hi != 0) begin
        if (hi == T1H) ones++;
        else if (hi == T0H) zeros++;
        hi = 0;
      end
      prev = b_pin;
      @(negedge clk);
      n++;
    end
    check_output("b_frame_done_seen", b_frame_done, 1);
    check_output("b_symbols", rises, 32);
    check_output("b_one_symbols", ones, 9);
    check_output("b_zero_symbols", zeros, 23);
    check_output("b_ready_cycles", ready_cycles, 1);
    check_output("b_busy_at_done", b_busy, 0);
    check_output("b_underrun", b_underrun, 0);
    b_pix_valid = 1'b0;
    repeat (3) @(negedge clk);

    check_output("scoreboard_empty", expect_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
